// File: rtl/multirate_pkg.sv
// Shared widths, FSM encoding and output rounding for the multirate filterbank.
package multirate_pkg;
   localparam int DATA_W    = 16;
   localparam int COEF_W    = 11;
   localparam int PROD_W    = DATA_W + COEF_W;
   localparam int ACC_W     = 30;
   localparam int OUT_SHIFT = 10;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   // Round half toward +inf, drop the Q1.10 fraction, then clamp to the sample range.
   function automatic logic signed [DATA_W-1:0] roundSat(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W:0] rounded;
      rounded = (ACC_W+1)'(acc) + (ACC_W+1)'(2 ** (OUT_SHIFT-1));
      rounded = rounded >>> OUT_SHIFT;
      if (rounded > (ACC_W+1)'(OUT_MAX)) return OUT_MAX;
      else if (rounded < (ACC_W+1)'(OUT_MIN)) return OUT_MIN;
      else return rounded[DATA_W-1:0];
   endfunction
endpackage

// File: rtl/multirate_mac_su.sv
// Combinational signed-sample x unsigned-magnitude multiply with sign-controlled
// accumulate; the clear input substitutes zero for the running sum.
module multirate_mac_su
   import multirate_pkg::*;
(
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic        [COEF_W-1:0] coefMag_i,
   input  logic                     coefNeg_i,
   input  logic                     accClear_i,
   input  logic signed [ACC_W-1:0]  acc_i,
   output logic signed [ACC_W-1:0]  acc_o
);
   logic signed [PROD_W-1:0] sampleExt;
   logic signed [PROD_W-1:0] coefExt;
   logic signed [PROD_W-1:0] product;
   logic signed [ACC_W-1:0]  productExt;
   logic signed [ACC_W-1:0]  accBase;

   // The magnitude is zero-extended so the multiply stays signed without a sign flip.
   assign sampleExt  = PROD_W'(sample_i);
   assign coefExt    = $signed(PROD_W'(coefMag_i));
   assign product    = sampleExt * coefExt;
   assign productExt = ACC_W'(product);
   assign accBase    = accClear_i ? '0 : acc_i;
   assign acc_o      = coefNeg_i ? (accBase - productExt) : (accBase + productExt);
endmodule

// File: rtl/multirate_interp_polyphase.sv
// Polyphase FIR interpolator: each accepted sample produces L outputs, one tap
// per cycle through a single shared multiply-accumulate.
module multirate_interp_polyphase
   import multirate_pkg::*;
#(
   parameter int L    = 2,
   parameter int TAPS = 8
)(
   input  logic                           ap_clk,
   input  logic                           ap_rst,
   input  logic signed [DATA_W-1:0]       in_tdata,
   input  logic                           in_tvalid,
   output logic                           in_tready,
   output logic signed [DATA_W-1:0]       out_tdata,
   output logic                           out_tvalid,
   input  logic                           out_tready,
   input  logic                           coef_wr_en,
   input  logic [$clog2(L*TAPS)-1:0]      coef_addr,
   input  logic [COEF_W-1:0]              coef_mag,
   input  logic                           coef_neg
);
   localparam int N      = L * TAPS;
   localparam int ADDR_W = $clog2(N);
   localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int PH_W   = (L > 1) ? $clog2(L) : 1;

   state_t                   state_q;
   logic signed [DATA_W-1:0] delayLine_q [TAPS];
   logic [COEF_W:0]          coefRam_q [N];
   logic [TAP_W-1:0]         tap_q;
   logic [PH_W-1:0]          phase_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic                     inReady_q;
   logic                     outValid_q;
   logic signed [DATA_W-1:0] outData_q;
   logic [ADDR_W-1:0]        rdAddr;
   logic [COEF_W:0]          rdCoef;

   // Coefficient n = k*L + p; each RAM word holds {neg, magnitude}.
   assign rdAddr = ADDR_W'(tap_q) * ADDR_W'(L) + ADDR_W'(phase_q);
   assign rdCoef = coefRam_q[rdAddr];

   multirate_mac_su uMac (
      .sample_i   (delayLine_q[tap_q]),
      .coefMag_i  (rdCoef[COEF_W-1:0]),
      .coefNeg_i  (rdCoef[COEF_W]),
      .accClear_i (tap_q == '0),
      .acc_i      (acc_q),
      .acc_o      (acc_d)
   );

   // Coefficients survive reset and may only change while no computation is in flight.
   always_ff @(posedge ap_clk) begin
      if (coef_wr_en && state_q == IDLE) begin
         coefRam_q[coef_addr] <= {coef_neg, coef_mag};
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= IDLE;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         acc_q      <= '0;
         tap_q      <= '0;
         phase_q    <= '0;
         for (int k = 0; k < TAPS; k++) delayLine_q[k] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_tvalid) begin
                  for (int k = TAPS-1; k > 0; k--) delayLine_q[k] <= delayLine_q[k-1];
                  delayLine_q[0] <= in_tdata;
                  phase_q   <= '0;
                  tap_q     <= '0;
                  acc_q     <= '0;
                  inReady_q <= 1'b0;
                  state_q   <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               if (tap_q == TAP_W'(TAPS-1)) begin
                  outData_q  <= roundSat(acc_d);
                  outValid_q <= 1'b1;
                  state_q    <= OUT;
               end else begin
                  tap_q <= tap_q + TAP_W'(1);
               end
            end
            OUT: begin
               if (out_tready) begin
                  outValid_q <= 1'b0;
                  if (phase_q < PH_W'(L-1)) begin
                     phase_q <= phase_q + PH_W'(1);
                     tap_q   <= '0;
                     acc_q   <= '0;
                     state_q <= MAC;
                  end else begin
                     inReady_q <= 1'b1;
                     state_q   <= IDLE;
                  end
               end
            end
            default: begin
               inReady_q  <= 1'b1;
               outValid_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign in_tready  = inReady_q;
   assign out_tvalid = outValid_q;
   assign out_tdata  = outData_q;
endmodule

// File: doc/multirate_interp_polyphase.md
Name: multirate_interp_polyphase

Overview:
Polyphase FIR interpolator (upsample by L) for the synthesis/output side of the multirate filterbank, the counterpart of the decimating analysis path. Each accepted input sample yields L output samples. Computation is time-multiplexed on one signed-data × unsigned-coefficient multiplier (16s × 11u → 27s) with sign-controlled add/subtract into an accumulator. Coefficients are runtime-loadable through a simple write port.

Parameters:
DATA_W, 16, input/output sample width, signed two's complement
COEF_W, 11, coefficient magnitude width, unsigned
PROD_W, 27, product width (DATA_W+COEF_W)
L, 2, interpolation factor (number of phases)
TAPS, 8, taps per phase; total coefficients N = L*TAPS
ACC_W, 30, accumulator width (PROD_W + clog2(TAPS))
OUT_SHIFT, 10, coefficient fractional bits (Q1.10 magnitude)

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous reset, active-high
in_tdata  in  DATA_W  input sample, signed
in_tvalid  in  1  input valid
in_tready  out  1  block accepts input
out_tdata  out  DATA_W  output sample, signed, saturated
out_tvalid  out  1  output valid
out_tready  in  1  downstream accepts output
coef_wr_en  in  1  coefficient write strobe
coef_addr  in  clog2(N)  coefficient index n = k*L + p
coef_mag  in  COEF_W  coefficient magnitude
coef_neg  in  1  coefficient sign (1 = negative)

Behaviour:
- One clock (ap_clk); reset synchronous active-high on ap_rst (already decided).
- Reset: state IDLE, in_tready=1 in the cycle after reset deasserts, out_tvalid=0, out_tdata=0, delay line x[0..TAPS-1]=0, accumulator=0, phase/tap counters=0. Coefficient RAM is NOT cleared by reset.
- FSM states: IDLE, MAC, OUT.
- IDLE: in_tready=1. On in_tvalid: shift delay line (x[0]←in_tdata, x[k]←x[k-1]), p←0, k←0, acc←0, go MAC.
- MAC: one tap per cycle: acc ± (x[k] * mag[k*L+p]); subtract when neg bit set. Product formed as signed × zero-extended unsigned, PROD_W bits. After TAPS cycles (k=TAPS-1), register rounded/saturated result to out_tdata, go OUT.
- OUT: out_tvalid=1, out_tdata stable until out_tready. On handshake: if p<L-1 then p←p+1, k←0, acc←0, go MAC; else go IDLE.
- Latency: input accepted cycle 0 → first out_tvalid cycle TAPS+1. Minimum throughput is one input per L*(TAPS+1)+1 cycles with out_tready held high.
- in_tready=0 in MAC and OUT; out_tvalid=0 in IDLE and MAC.
- Output arithmetic: y = sat_DATA_W((acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT). Rounding is round-half-up (toward +inf). Saturation clamps to +32767 / -32768.
- Accumulator never overflows with default widths: |x*mag| < 2^26, and 8 terms < 2^29.
- Coefficient writes are accepted only in IDLE. When the write and an input handshake occur in the same IDLE cycle, the write lands before the MAC starts. Writes in MAC/OUT are ignored (no error flag).
- Reset asserted mid-MAC or in OUT: output is dropped, out_tvalid=0 next cycle, delay line cleared.
- Passband gain L compensation is folded into coefficients by software.

Decomposition:
- Shared package multirate_pkg: DATA_W, COEF_W, PROD_W, ACC_W, OUT_SHIFT, state enum (IDLE/MAC/OUT), round/saturate function.
- One sub-module: multirate_mac_su (registered-free signed×unsigned multiply plus add/sub accumulate, with acc clear input).
- Coefficient RAM and delay line stay inline.

Test Plan:
- Impulse: h[0]=+1024, others 0; inputs 100,0,0 → outputs 100,0,0,0,0,0.
- Phase order: h[0]=+1024, h[1]=+512, others 0; input 200 → outputs 200 then 100.
- Rounding: h[0]=+512 only; input 3 → first output 2; input -3 → first output -1.
- Saturation: all 16 coefs mag 2047 neg=0; input +32767 → both outputs 32767. All neg=1 with input -32768 → 32767; input +32767 → -32768.
- Backpressure: out_tready low 5 cycles at first out_tvalid → out_tdata stable, in_tready=0, no sample lost. Also: coefficient write during MAC is ignored, verified by output unchanged.
- Reset mid-MAC: assert ap_rst at MAC tap 4 → next cycle out_tvalid=0, in_tready=1. Subsequent impulse (coefs retained) reproduces the impulse-test outputs exactly.
